// File: rtl/game_tick_gen_pkg.sv
// Shared timing constants and channel map for the game timebase generator.
// Default divisors assume a 100 MHz board clock.
package game_tick_gen_pkg;

    localparam int CLK_HZ    = 100_000_000;
    localparam int DIV_1S    = CLK_HZ;
    localparam int DIV_GHOST = CLK_HZ / 8;
    localparam int DIV_ANIM  = CLK_HZ / 12;
    localparam int DIV_BLINK = CLK_HZ / 4;

    // Width that can hold the slowest (1 s) divisor.
    localparam int CNT_W_DEF = $clog2(DIV_1S + 1);
    localparam int N_CH_DEF  = 4;

    // Channel index map used by the game logic.
    typedef enum int unsigned {
        CH_SEC   = 0,
        CH_GHOST = 1,
        CH_ANIM  = 2,
        CH_BLINK = 3
    } ch_id_e;

    // Width of a channel select; at least one bit even for a single channel.
    function automatic int ch_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_tick_gen_channel.sv
// One timebase channel: divisor register, wrap counter, tick strobe and
// 50% square output.
module game_tick_gen_channel
    import game_tick_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DIV_1S
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pause,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_ld_div,
    output logic             o_tick,
    output logic             o_sq
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_tick;
    logic             r_sq;

    logic [CNT_W-1:0] w_d;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;

    // Divisors 0 and 1 both mean "every cycle"; >= makes a shrunk divisor
    // wrap on the next enabled edge instead of running to 2^CNT_W.
    assign w_d    = (r_div < CNT_W'(2)) ? CNT_W'(1) : r_div;
    assign w_last = w_d - CNT_W'(1);
    assign w_wrap = (r_cnt >= w_last);

    // Divisor register: a write lands at the edge and is used from the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= CNT_W'(DEF_DIV);
        end else if (i_ld) begin
            r_div <= i_ld_div;
        end
    end

    // Counter, tick and square: clear beats pause, pause beats enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
        end else if (i_pause || !i_en) begin
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_sq   <= ~r_sq;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel programmable tick generator. Each channel derives its own
// timebase from clk; divisors are writable at runtime through a simple
// address/data strobe and all channels share a global pause.
module game_tick_gen
    import game_tick_gen_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int DEF_DIV = DIV_1S,
    localparam int CH_W    = ch_sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [N_CH-1:0]  ch_clr,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    // Per-channel load strobes; an address with no channel behind it
    // matches nothing, so the write is dropped.
    logic [N_CH-1:0] w_ld;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_ld[g] = wr_en && (wr_ch == CH_W'(g));

        game_tick_gen_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_pause  (pause),
            .i_en     (ch_en[g]),
            .i_clr    (ch_clr[g]),
            .i_ld     (w_ld[g]),
            .i_ld_div (wr_div),
            .o_tick   (tick[g]),
            .o_sq     (sq[g])
        );
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen with CNT_W=8, DEF_DIV=5, N_CH=4.
module tb_game_tick_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] ch_en = '0;
    logic [3:0] ch_clr = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_div = '0;
    logic [3:0] tick;
    logic [3:0] sq;

    game_tick_gen #(.N_CH(4), .CNT_W(8), .DEF_DIV(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pause  (pause),
        .ch_en  (ch_en),
        .ch_clr (ch_clr),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .tick   (tick),
        .sq     (sq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference state
    int         m_cnt [4];
    int         m_div [4];
    logic [3:0] m_tick;
    logic [3:0] m_sq;

    logic [7:0] sb_q [$];
    logic [3:0] s_tick;
    logic [3:0] s_sq;

    typedef struct {
        logic       p;
        logic [3:0] en;
        logic [3:0] clr;
        logic [3:0] etick;
        logic [3:0] esq;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_div[i] = 5;
        end
        m_tick = '0;
        m_sq = '0;
    endtask

    task automatic model_edge(input logic p, input logic [3:0] en, input logic [3:0] clr,
                              input logic we, input logic [1:0] wch, input logic [7:0] wdiv);
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (m_div[i] < 2) ? 1 : m_div[i];
            if (clr[i]) begin
                m_cnt[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (p || !en[i]) begin
                m_tick[i] = 1'b0;
            end else if (m_cnt[i] >= d - 1) begin
                m_cnt[i] = 0; m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
            end else begin
                m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0;
            end
            if (we && int'(wch) == i) m_div[i] = int'(wdiv);
        end
    endtask

    // Drive one cycle of inputs, push the expected result, sample after the edge.
    task automatic step(input logic p, input logic [3:0] en, input logic [3:0] clr,
                        input logic we, input logic [1:0] wch, input logic [7:0] wdiv,
                        input bit use_tab, input logic [3:0] et, input logic [3:0] es,
                        input string nm);
        logic [7:0] e;
        pause = p; ch_en = en; ch_clr = clr; wr_en = we; wr_ch = wch; wr_div = wdiv;
        model_edge(p, en, clr, we, wch, wdiv);
        if (use_tab) sb_q.push_back({et, es});
        else sb_q.push_back({m_tick, m_sq});
        @(posedge clk);
        #1;
        ch_clr = '0; wr_en = 1'b0;
        s_tick = tick;
        s_sq = sq;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_tick"}, {28'd0, tick}, {28'd0, e[7:4]});
            chk({nm, "_sq"}, {28'd0, sq}, {28'd0, e[3:0]});
        end
    endtask

    task automatic stepm(input logic p, input logic [3:0] en, input logic [3:0] clr,
                         input logic we, input logic [1:0] wch, input logic [7:0] wdiv,
                         input string nm);
        step(p, en, clr, we, wch, wdiv, 1'b0, 4'h0, 4'h0, nm);
    endtask

    // Reset pulse between edges, 1 time unit wide, checked while still low.
    task automatic async_reset(input string nm);
        #3;
        rst_n = 1'b0;
        #1;
        chk({nm, "_tick"}, {28'd0, tick}, 32'd0);
        chk({nm, "_sq"}, {28'd0, sq}, 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mkv(input logic [3:0] en, input logic [3:0] clr,
                                 input logic [3:0] et, input logic [3:0] es);
        vec_t v;
        v.p = 1'b0; v.en = en; v.clr = clr; v.etick = et; v.esq = es;
        return v;
    endfunction

    int c0, c1;

    initial begin
        // Free-running from reset: wraps at enabled edges 5, 10, 15
        vecs[0]  = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[1]  = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[2]  = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[4]  = mkv(4'hF, 4'h0, 4'hF, 4'hF);
        vecs[5]  = mkv(4'hF, 4'h0, 4'h0, 4'hF);
        vecs[6]  = mkv(4'hF, 4'h0, 4'h0, 4'hF);
        vecs[7]  = mkv(4'hF, 4'h0, 4'h0, 4'hF);
        vecs[8]  = mkv(4'hF, 4'h0, 4'h0, 4'hF);
        vecs[9]  = mkv(4'hF, 4'h0, 4'hF, 4'h0);
        vecs[10] = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[11] = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[12] = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[13] = mkv(4'hF, 4'h0, 4'h0, 4'h0);
        vecs[14] = mkv(4'hF, 4'h0, 4'hF, 4'hF);
        vecs[15] = mkv(4'hF, 4'h8, 4'h0, 4'h7);

        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tick", {28'd0, tick}, 32'd0);
        chk("rst_sq", {28'd0, sq}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_tick", {28'd0, tick}, 32'd0);
        chk("rst_hold_sq", {28'd0, sq}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++)
            step(vecs[k].p, vecs[k].en, vecs[k].clr, 1'b0, 2'd0, 8'd0,
                 1'b1, vecs[k].etick, vecs[k].esq, $sformatf("tab%0d", k));

        // ch1: clear plus divisor 3 on the same edge, others keep 5
        stepm(1'b0, 4'hF, 4'h2, 1'b1, 2'd1, 8'd3, "s2_wr");
        c0 = 0; c1 = 0;
        for (int k = 0; k < 12; k++) begin
            stepm(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s2_%0d", k));
            c0 += int'(s_tick[0]);
            c1 += int'(s_tick[1]);
        end
        chk("s2_ch1_ticks", c1, 4);
        chk("s2_ch0_ticks", c0, 2);

        async_reset("s3_rst");

        // ch0 reaches cnt=4, then shrink divisor to 2 while idle
        for (int k = 0; k < 4; k++)
            stepm(1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s3_run%0d", k));
        stepm(1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 8'd2, "s3_wr");
        chk("s3_wr_notick", {31'd0, s_tick[0]}, 32'd0);
        stepm(1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, "s3_a");
        chk("s3_wrap_next", {31'd0, s_tick[0]}, 32'd1);
        stepm(1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, "s3_b");
        chk("s3_gap", {31'd0, s_tick[0]}, 32'd0);
        stepm(1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 8'd0, "s3_c");
        chk("s3_period2", {31'd0, s_tick[0]}, 32'd1);

        // ch3 paused for 7 cycles at cnt=2
        stepm(1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, "s4_r0");
        stepm(1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, "s4_r1");
        for (int k = 0; k < 7; k++) begin
            stepm(1'b1, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s4_p%0d", k));
            chk($sformatf("s4_paused%0d", k), {28'd0, s_tick}, 32'd0);
        end
        stepm(1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, "s4_x0");
        chk("s4_resume1", {31'd0, s_tick[3]}, 32'd0);
        stepm(1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, "s4_x1");
        chk("s4_resume2", {31'd0, s_tick[3]}, 32'd0);
        stepm(1'b0, 4'h8, 4'h0, 1'b0, 2'd0, 8'd0, "s4_x2");
        chk("s4_resume3", {31'd0, s_tick[3]}, 32'd1);

        // ch2: clear with pause and divisor 0 write
        for (int k = 0; k < 7; k++) begin
            stepm(1'b0, 4'h4, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s5_r%0d", k));
            if (k == 4) chk("s5_sq_set", {31'd0, s_sq[2]}, 32'd1);
        end
        stepm(1'b1, 4'h4, 4'h4, 1'b1, 2'd2, 8'd0, "s5_clr");
        chk("s5_clr_sq", {31'd0, s_sq[2]}, 32'd0);
        chk("s5_clr_tick", {31'd0, s_tick[2]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            stepm(1'b0, 4'h4, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s5_run%0d", k));
            chk($sformatf("s5_every%0d", k), {31'd0, s_tick[2]}, 32'd1);
        end

        // Mid-count asynchronous reset while ch2 ticks every cycle
        for (int k = 0; k < 3; k++)
            stepm(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s6_r%0d", k));
        chk("s6_pre_tick", {31'd0, s_tick[2]}, 32'd1);
        async_reset("s6_rst");
        for (int k = 0; k < 4; k++) begin
            stepm(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'd0, $sformatf("s6_a%0d", k));
            chk($sformatf("s6_quiet%0d", k), {28'd0, s_tick}, 32'd0);
        end
        stepm(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'd0, "s6_a4");
        chk("s6_defdiv", {28'd0, s_tick}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
